// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port, variable-latency memory between instruction fetch and data access.
// Data has fixed priority, fetch is forced after MAX_STARVE consecutive data grants, and a watchdog aborts stuck accesses.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_STARVE = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_done,
    output logic                if_err,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic                d_done,
    output logic                d_err,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_ready,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    localparam int STRB_W = DATA_W / 8;
    localparam int SC_W   = $clog2(MAX_STARVE + 1);
    localparam int TC_W   = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, GRANT_IF, GRANT_D} state_t;

    state_t              state, state_n;
    logic [SC_W-1:0]     starve_cnt, starve_n;
    logic [TC_W-1:0]     tmo_cnt, tmo_n;
    logic                mem_req_n, mem_we_n, busy_n;
    logic [ADDR_W-1:0]   mem_addr_n;
    logic [DATA_W-1:0]   mem_wdata_n, if_rdata_n, d_rdata_n;
    logic [STRB_W-1:0]   mem_wstrb_n;
    logic                if_done_n, if_err_n, d_done_n, d_err_n;
    logic                if_elig, d_elig;

    // A requester whose done is high this cycle is still holding req; don't re-grant it.
    assign if_elig = if_req && !if_done;
    assign d_elig  = d_req && !d_done;

    always_comb begin
        state_n     = state;
        starve_n    = starve_cnt;
        tmo_n       = tmo_cnt;
        mem_req_n   = mem_req;
        mem_we_n    = mem_we;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        mem_wstrb_n = mem_wstrb;
        if_rdata_n  = if_rdata;
        d_rdata_n   = d_rdata;
        if_done_n   = 1'b0;
        if_err_n    = 1'b0;
        d_done_n    = 1'b0;
        d_err_n     = 1'b0;

        case (state)
            IDLE: begin
                if (d_elig && (starve_cnt < SC_W'(MAX_STARVE) || !if_elig)) begin
                    state_n     = GRANT_D;
                    mem_req_n   = 1'b1;
                    mem_we_n    = d_we;
                    mem_addr_n  = d_addr;
                    mem_wdata_n = d_wdata;
                    mem_wstrb_n = d_we ? d_wstrb : '0;
                    tmo_n       = '0;
                    if (!if_elig)
                        starve_n = '0;
                    else if (starve_cnt != SC_W'(MAX_STARVE))
                        starve_n = starve_cnt + 1'b1;
                end else if (if_elig) begin
                    state_n     = GRANT_IF;
                    mem_req_n   = 1'b1;
                    mem_we_n    = 1'b0;
                    mem_addr_n  = if_addr;
                    mem_wstrb_n = '0;
                    tmo_n       = '0;
                    starve_n    = '0;
                end
            end
            GRANT_IF, GRANT_D: begin
                if (mem_ready) begin
                    state_n   = IDLE;
                    mem_req_n = 1'b0;
                    if (state == GRANT_IF) begin
                        if_done_n  = 1'b1;
                        if_rdata_n = mem_rdata;
                    end else begin
                        d_done_n = 1'b1;
                        if (!mem_we)
                            d_rdata_n = mem_rdata;
                    end
                end else if (tmo_cnt == TC_W'(TIMEOUT - 1)) begin
                    // This is the TIMEOUT-th cycle with mem_req high and no ready.
                    state_n   = IDLE;
                    mem_req_n = 1'b0;
                    if (state == GRANT_IF) begin
                        if_done_n = 1'b1;
                        if_err_n  = 1'b1;
                    end else begin
                        d_done_n = 1'b1;
                        d_err_n  = 1'b1;
                    end
                end else begin
                    tmo_n = tmo_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            tmo_cnt    <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            if_done    <= 1'b0;
            if_err     <= 1'b0;
            d_done     <= 1'b0;
            d_err      <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            starve_cnt <= starve_n;
            tmo_cnt    <= tmo_n;
            mem_req    <= mem_req_n;
            mem_we     <= mem_we_n;
            mem_addr   <= mem_addr_n;
            mem_wdata  <= mem_wdata_n;
            mem_wstrb  <= mem_wstrb_n;
            if_rdata   <= if_rdata_n;
            d_rdata    <= d_rdata_n;
            if_done    <= if_done_n;
            if_err     <= if_err_n;
            d_done     <= d_done_n;
            d_err      <= d_err_n;
            busy       <= busy_n;
        end
    end

endmodule
